// File: rtl/uart_tx_buffered.sv
// Buffered UART transmitter: valid/ready write port into a circular FIFO,
// drained back-to-back by a framing FSM with configurable width/parity/stop.
module uart_tx_buffered #(
  parameter int CLK_FREQ   = 27_000_000,
  parameter int BAUD_RATE  = 4800,
  parameter int DATA_BITS  = 8,
  parameter int PARITY     = 0,
  parameter int STOP_BITS  = 1,
  parameter int FIFO_DEPTH = 16
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic [DATA_BITS-1:0]          data,
  input  logic                          data_valid,
  output logic                          data_ready,
  output logic                          tx,
  output logic                          busy,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_level,
  output logic                          overflow
);
  localparam int CPB = CLK_FREQ / BAUD_RATE;
  localparam int AW  = $clog2(FIFO_DEPTH);
  localparam int CW  = $clog2(CPB);
  localparam logic [CW-1:0] CNT_LAST  = CW'(CPB - 1);
  localparam logic [3:0]    DATA_LAST = 4'(DATA_BITS - 1);
  localparam logic [3:0]    STOP_LAST = 4'(STOP_BITS - 1);

  typedef enum logic [2:0] {S_IDLE, S_START, S_DATA, S_PARITY, S_STOP} state_t;

  state_t               state;
  logic [CW-1:0]        cnt;
  logic [3:0]           bit_cnt;
  logic [DATA_BITS-1:0] shift, word;

  logic [DATA_BITS-1:0] mem [FIFO_DEPTH];
  logic [AW:0]          wr_ptr, rd_ptr;
  logic                 full, empty, push, pop, stop_done, par_bit;
  logic [DATA_BITS-1:0] head;

  // Extra pointer bit distinguishes full from empty when addresses match.
  assign empty      = (wr_ptr == rd_ptr);
  assign full       = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign data_ready = !full;
  assign push       = data_valid && !full;
  assign fifo_level = wr_ptr - rd_ptr;
  assign head       = mem[rd_ptr[AW-1:0]];
  assign busy       = (state != S_IDLE) || !empty;

  assign stop_done = (state == S_STOP) && (cnt == CNT_LAST) && (bit_cnt == STOP_LAST);
  assign pop       = !empty && ((state == S_IDLE) || stop_done);
  assign par_bit   = (PARITY == 2) ? ^word : ~^word;

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr[AW-1:0]] <= data;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      overflow <= 1'b0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      if (data_valid && !data_ready) overflow <= 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= S_IDLE;
      tx      <= 1'b1;
      cnt     <= '0;
      bit_cnt <= '0;
      shift   <= '0;
      word    <= '0;
    end else begin
      // Every state exit happens at CNT_LAST, so the wrap restarts the count on entry.
      cnt <= (cnt == CNT_LAST) ? '0 : cnt + CW'(1);
      case (state)
        S_IDLE: begin
          cnt <= '0;
          tx  <= 1'b1;
          if (pop) begin
            shift   <= head;
            word    <= head;
            bit_cnt <= '0;
            tx      <= 1'b0;
            state   <= S_START;
          end
        end
        S_START: begin
          if (cnt == CNT_LAST) begin
            tx    <= shift[0];
            state <= S_DATA;
          end
        end
        S_DATA: begin
          if (cnt == CNT_LAST) begin
            if (bit_cnt == DATA_LAST) begin
              bit_cnt <= '0;
              if (PARITY != 0) begin
                tx    <= par_bit;
                state <= S_PARITY;
              end else begin
                tx    <= 1'b1;
                state <= S_STOP;
              end
            end else begin
              bit_cnt <= bit_cnt + 4'd1;
              shift   <= shift >> 1;
              tx      <= shift[1];
            end
          end
        end
        S_PARITY: begin
          if (cnt == CNT_LAST) begin
            tx    <= 1'b1;
            state <= S_STOP;
          end
        end
        S_STOP: begin
          if (cnt == CNT_LAST) begin
            if (bit_cnt == STOP_LAST) begin
              bit_cnt <= '0;
              if (pop) begin
                shift <= head;
                word  <= head;
                tx    <= 1'b0;
                state <= S_START;
              end else begin
                tx    <= 1'b1;
                state <= S_IDLE;
              end
            end else begin
              bit_cnt <= bit_cnt + 4'd1;
            end
          end
        end
        default: begin
          tx    <= 1'b1;
          state <= S_IDLE;
        end
      endcase
    end
  end
endmodule
